// File: rtl/pk_cmd_frontend_if.sv
// Host byte link plus core operand/handshake bundle for the password-keeper front-end.
// The front-end is the slave; the host/core side (or bench) is the master.
interface pk_cmd_frontend_if;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic         go;
   logic [127:0] master_key;
   logic [127:0] account;
   logic [127:0] password;
   logic [127:0] password_enc;
   logic         done;
   logic         boot_done;
   logic         err;

   modport slave (
      input  in_valid, in_data, out_ready, password_enc, done, boot_done,
      output in_ready, out_valid, out_data, go, master_key, account, password, err
   );

   modport master (
      output in_valid, in_data, out_ready, password_enc, done, boot_done,
      input  in_ready, out_valid, out_data, go, master_key, account, password, err
   );
endinterface

// File: rtl/pk_cmd_frontend.sv
// Command front-end: packs a 49-byte encrypt frame into core operands, fires the core,
// then streams the 128-bit result back out as 16 bytes, MSB first.
module pk_cmd_frontend #(
   parameter logic [7:0] CMD_ENC = 8'hA5,
   parameter int         TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst,
   pk_cmd_frontend_if.slave   bus
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_BOOT = 3'd0,
      ST_IDLE = 3'd1,
      ST_LOAD = 3'd2,
      ST_FIRE = 3'd3,
      ST_WAIT = 3'd4,
      ST_SEND = 3'd5
   } state_e;

   state_e         state_q, state_d;
   logic [5:0]     byte_cnt_q, byte_cnt_d;
   logic [3:0]     send_cnt_q, send_cnt_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [383:0]   load_q, load_d;
   logic [127:0]   shift_q, shift_d;
   logic           err_q, err_d;

   logic           in_ready_s;
   logic           in_acc_s;
   logic           out_acc_s;

   // Every output is a decode of, or a slice of, a flop so no input reaches an output.
   assign in_ready_s     = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign in_acc_s       = bus.in_valid && in_ready_s;
   assign out_acc_s      = bus.out_ready && (state_q == ST_SEND);

   assign bus.in_ready   = in_ready_s;
   assign bus.out_valid  = (state_q == ST_SEND);
   assign bus.out_data   = shift_q[127:120];
   assign bus.go         = (state_q == ST_FIRE);
   assign bus.err        = err_q;
   assign bus.master_key = load_q[383:256];
   assign bus.account    = load_q[255:128];
   assign bus.password   = load_q[127:0];

   // Next-state, counter and datapath update.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      send_cnt_d = send_cnt_q;
      tmo_d      = tmo_q;
      load_d     = load_q;
      shift_d    = shift_q;
      err_d      = 1'b0;
      case (state_q)
         ST_BOOT: begin
            if (bus.boot_done) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BOOT;
            end
         end
         ST_IDLE: begin
            if (in_acc_s) begin
               if (bus.in_data == CMD_ENC) begin
                  state_d    = ST_LOAD;
                  byte_cnt_d = 6'd0;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (in_acc_s) begin
               load_d = {load_q[375:0], bus.in_data};
               if (byte_cnt_q == 6'd47) begin
                  state_d = ST_FIRE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 6'd1;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_FIRE: begin
            tmo_d   = '0;
            state_d = ST_WAIT;
         end
         // done takes priority over the timeout limit in the same cycle.
         ST_WAIT: begin
            if (bus.done) begin
               shift_d    = bus.password_enc;
               send_cnt_d = 4'd0;
               state_d    = ST_SEND;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
            end
         end
         ST_SEND: begin
            if (out_acc_s) begin
               shift_d = {shift_q[119:0], 8'h00};
               if (send_cnt_q == 4'd15) begin
                  state_d = ST_IDLE;
               end else begin
                  send_cnt_d = send_cnt_q + 4'd1;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_BOOT;
         byte_cnt_q <= 6'd0;
         send_cnt_q <= 4'd0;
         tmo_q      <= '0;
         load_q     <= 384'd0;
         shift_q    <= 128'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         send_cnt_q <= send_cnt_d;
         tmo_q      <= tmo_d;
         load_q     <= load_d;
         shift_q    <= shift_d;
         err_q      <= err_d;
      end
   end

endmodule
